// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: mul/div ops, FSM states, ALU ops.
package exec_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIVU = 2'b10,
    MD_REMU = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

endpackage

// File: rtl/execute_md_if.sv
// ID/EX -> EX bundle: decoded controls, operands, forwarding taps and EX results.
interface execute_md_if #(
  parameter int DATA_W  = 32,
  parameter int FWD_SRC = 2
);
  localparam int FSEL_W = $clog2(FWD_SRC + 1);
  localparam int SH_W   = $clog2(DATA_W);

  logic                       valid_in;
  logic                       flush;
  logic                       ALUSrc;
  logic                       Branch;
  logic                       bne;
  logic [3:0]                 ALUOp;
  logic [1:0]                 mdOp;
  logic [SH_W-1:0]            shamt_EX;
  logic [FSEL_W-1:0]          forwardA;
  logic [FSEL_W-1:0]          forwardB;
  logic [DATA_W-1:0]          readData1;
  logic [DATA_W-1:0]          readData2;
  logic [DATA_W-1:0]          extImm;
  logic [FWD_SRC*DATA_W-1:0]  fwdData;
  logic [DATA_W-1:0]          aluRes_EX;
  logic [DATA_W-1:0]          forwardB_EX;
  logic                       taken;
  logic                       stall;
  logic                       res_valid;

  modport master (
    output valid_in, flush, ALUSrc, Branch, bne, ALUOp, mdOp, shamt_EX,
           forwardA, forwardB, readData1, readData2, extImm, fwdData,
    input  aluRes_EX, forwardB_EX, taken, stall, res_valid
  );

  modport slave (
    input  valid_in, flush, ALUSrc, Branch, bne, ALUOp, mdOp, shamt_EX,
           forwardA, forwardB, readData1, readData2, extImm, fwdData,
    output aluRes_EX, forwardB_EX, taken, stall, res_valid
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// acc holds the product (MUL) or partial remainder (DIV); x holds the
// shifting multiplicand (MUL) or dividend-becoming-quotient (DIV).
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              start,
  input  md_op_e            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_op_e            op_q, op_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W:0]   r_sh;
  logic              r_ge;

  assign busy = (cnt_q != '0);
  // done flags the cycle in which the final step is being taken
  assign done = busy && (cnt_q == CNT_W'(1));
  assign r_sh = {acc_q, x_q[DATA_W-1]};
  assign r_ge = (r_sh >= {1'b0, y_q});

  // Load on start, otherwise one shift-add / restoring-subtract step per cycle
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    if (kill) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CNT_W'(DATA_W);
      op_d  = op;
      acc_d = '0;
      x_d   = a;
      y_d   = b;
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (op_q == MD_MUL) begin
        acc_d = acc_q + (y_q[0] ? x_q : '0);
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
      end else begin
        // divisor 0 always compares >=, giving all-ones quotient and remainder = dividend
        acc_d = r_ge ? DATA_W'(r_sh - {1'b0, y_q}) : r_sh[DATA_W-1:0];
        x_d   = {x_q[DATA_W-2:0], r_ge};
      end
    end
  end

  // Operand/result state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= MD_NONE;
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign result = (op_q == MD_DIVU) ? x_q : acc_q;
endmodule

// File: rtl/execute_md.sv
// Execute stage: operand forwarding, ALU, branch compare and an iterative
// mul/div unit that stalls the front end while it runs.
module execute_md
  import exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FWD_SRC = 2
) (
  input  logic         clk,
  input  logic         reset,
  execute_md_if.slave  io
);
  localparam int FSEL_W = $clog2(FWD_SRC + 1);

  md_state_e         state_q, state_d;
  logic [DATA_W-1:0] opa, opb, op2, alu_res, md_result;
  logic              md_start, md_busy, md_done, br_hit;

  // Forwarding muxes; selects beyond the last tap yield zero
  always_comb begin
    opa = '0;
    opb = '0;
    if (io.forwardA == '0) opa = io.readData1;
    if (io.forwardB == '0) opb = io.readData2;
    for (int k = 0; k < FWD_SRC; k++) begin
      if (io.forwardA == FSEL_W'(k + 1)) opa = io.fwdData[k*DATA_W +: DATA_W];
      if (io.forwardB == FSEL_W'(k + 1)) opb = io.fwdData[k*DATA_W +: DATA_W];
    end
  end

  assign op2            = io.ALUSrc ? io.extImm : opb;
  assign io.forwardB_EX = opb;
  assign br_hit         = io.bne ? (opa != op2) : (opa == op2);

  // ALU; shifts act on operand 2 by shamt
  always_comb begin
    alu_res = '0;
    case (io.ALUOp)
      ALU_ADD:  alu_res = opa + op2;
      ALU_SUB:  alu_res = opa - op2;
      ALU_AND:  alu_res = opa & op2;
      ALU_OR:   alu_res = opa | op2;
      ALU_XOR:  alu_res = opa ^ op2;
      ALU_SLL:  alu_res = op2 << io.shamt_EX;
      ALU_SRL:  alu_res = op2 >> io.shamt_EX;
      ALU_SRA:  alu_res = $signed(op2) >>> io.shamt_EX;
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(opa) < $signed(op2)};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, opa < op2};
      default:  alu_res = '0;
    endcase
  end

  assign md_start = (state_q == ST_IDLE) && io.valid_in && !io.flush &&
                    (io.mdOp != MD_NONE);

  muldiv_iter #(.DATA_W(DATA_W)) u_md (
    .clk    (clk),
    .reset  (reset),
    .kill   (io.flush),
    .start  (md_start),
    .op     (md_op_e'(io.mdOp)),
    .a      (opa),
    .b      (op2),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Next state: DONE lasts one cycle so the still-presented instruction is not re-accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (md_start) state_d = ST_BUSY;
      ST_BUSY: begin
        if (io.flush)                state_d = ST_IDLE;
        else if (md_busy && md_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Outputs: ALU path only in IDLE, silent while BUSY, latched result in DONE
  always_comb begin
    io.stall     = 1'b0;
    io.res_valid = 1'b0;
    io.aluRes_EX = '0;
    io.taken     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        io.stall     = md_start;
        io.res_valid = io.valid_in && !io.flush && (io.mdOp == MD_NONE);
        io.aluRes_EX = alu_res;
        io.taken     = io.valid_in && io.Branch && !io.flush && br_hit;
      end
      ST_BUSY: io.stall = 1'b1;
      ST_DONE: begin
        io.res_valid = !io.flush;
        io.aluRes_EX = md_result;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: vector table for the combinational path,
// hand-written sequences for mul/div latency, latching, abort and reset.
module tb_execute_md;
  import exec_pkg::*;

  localparam int DATA_W  = 32;
  localparam int FWD_SRC = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  execute_md_if #(.DATA_W(DATA_W), .FWD_SRC(FWD_SRC)) bus ();

  execute_md #(.DATA_W(DATA_W), .FWD_SRC(FWD_SRC)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, t0, t1;
    logic [3:0]  aop;
    logic        asrc, br, bne, vld, fl;
    logic [4:0]  sh;
    logic [31:0] e_res, e_fb;
    logic        e_tk, e_rv;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic [1:0] fa, fb, logic [31:0] rd1, rd2, imm, t0, t1,
                              logic [3:0] aop, logic asrc, br, bne, vld, fl, logic [4:0] sh,
                              logic [31:0] e_res, e_fb, logic e_tk, e_rv);
    vec_t v;
    v.fa = fa; v.fb = fb; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.t0 = t0; v.t1 = t1;
    v.aop = aop; v.asrc = asrc; v.br = br; v.bne = bne; v.vld = vld; v.fl = fl; v.sh = sh;
    v.e_res = e_res; v.e_fb = e_fb; v.e_tk = e_tk; v.e_rv = e_rv;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.valid_in = 0; bus.flush = 0; bus.ALUSrc = 0; bus.Branch = 0; bus.bne = 0;
    bus.ALUOp = ALU_ADD; bus.mdOp = MD_NONE; bus.shamt_EX = 0;
    bus.forwardA = 0; bus.forwardB = 0;
    bus.readData1 = 0; bus.readData2 = 0; bus.extImm = 0; bus.fwdData = 0;
  endtask

  // Issue a mul/div from the register file and check latency, result and one-cycle valid
  task automatic run_md(string nm, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    idle_inputs();
    bus.valid_in = 1; bus.mdOp = op; bus.readData1 = a; bus.readData2 = b;
    #1;
    chk({nm, " accept_stall"}, 32'(bus.stall), 32'd1);
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk({nm, " stall_cycles"}, 32'(n), 32'd33);
    chk({nm, " res_valid"}, 32'(bus.res_valid), 32'd1);
    chk({nm, " result"}, bus.aluRes_EX, exp);
    bus.valid_in = 0; bus.mdOp = MD_NONE;
    @(posedge clk); #1;
    chk({nm, " valid_one_cycle"}, 32'(bus.res_valid), 32'd0);
    chk({nm, " no_reaccept"}, 32'(bus.stall), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, 5, 0, 32'h10, 0, ALU_ADD, 0, 0, 0, 1, 0, 0, 32'h15, 5, 0, 1);
    vecs[1]  = mk(0, 2, 20, 0, 0, 0, 7, ALU_SUB, 0, 0, 0, 1, 0, 0, 13, 7, 0, 1);
    vecs[2]  = mk(3, 0, 32'h55, 9, 0, 32'h77, 32'h88, ALU_ADD, 0, 0, 0, 1, 0, 0, 9, 9, 0, 1);
    vecs[3]  = mk(0, 0, 32'hFF, 0, 32'h0F, 0, 0, ALU_AND, 1, 0, 0, 1, 0, 0, 32'h0F, 0, 0, 1);
    vecs[4]  = mk(0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, ALU_SLT, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1);
    vecs[5]  = mk(0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, ALU_SLTU, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
    vecs[6]  = mk(0, 0, 3, 32'h8000_0000, 0, 0, 0, ALU_SRA, 0, 0, 0, 1, 0, 4, 32'hF800_0000, 32'h8000_0000, 0, 1);
    vecs[7]  = mk(0, 0, 5, 5, 0, 0, 0, ALU_SUB, 0, 1, 1, 1, 0, 0, 0, 5, 0, 1);
    vecs[8]  = mk(0, 0, 5, 6, 0, 0, 0, ALU_SUB, 0, 1, 1, 1, 0, 0, 32'hFFFF_FFFF, 6, 1, 1);
    vecs[9]  = mk(0, 0, 5, 5, 0, 0, 0, ALU_SUB, 0, 1, 0, 1, 0, 0, 0, 5, 1, 1);
    vecs[10] = mk(0, 0, 5, 5, 0, 0, 0, ALU_SUB, 0, 1, 0, 1, 1, 0, 0, 5, 0, 0);
    vecs[11] = mk(0, 0, 1, 2, 0, 0, 0, ALU_ADD, 0, 1, 1, 0, 0, 0, 3, 2, 0, 0);
    vecs[12] = mk(0, 1, 32'hF0, 32'h33, 0, 32'h0F, 0, ALU_OR, 0, 0, 0, 1, 0, 0, 32'hFF, 32'h0F, 0, 1);

    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset res_valid", 32'(bus.res_valid), 32'd0);
    chk("reset taken", 32'(bus.taken), 32'd0);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      bus.forwardA = vecs[i].fa; bus.forwardB = vecs[i].fb;
      bus.readData1 = vecs[i].rd1; bus.readData2 = vecs[i].rd2; bus.extImm = vecs[i].imm;
      bus.fwdData = {vecs[i].t1, vecs[i].t0};
      bus.ALUOp = vecs[i].aop; bus.ALUSrc = vecs[i].asrc; bus.Branch = vecs[i].br;
      bus.bne = vecs[i].bne; bus.valid_in = vecs[i].vld; bus.flush = vecs[i].fl;
      bus.shamt_EX = vecs[i].sh; bus.mdOp = MD_NONE;
      #1;
      chk($sformatf("vec%0d aluRes", i), bus.aluRes_EX, vecs[i].e_res);
      chk($sformatf("vec%0d forwardB_EX", i), bus.forwardB_EX, vecs[i].e_fb);
      chk($sformatf("vec%0d taken", i), 32'(bus.taken), 32'(vecs[i].e_tk));
      chk($sformatf("vec%0d res_valid", i), 32'(bus.res_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d stall", i), 32'(bus.stall), 32'd0);
    end

    run_md("mul", MD_MUL, 32'h0001_0003, 32'h0000_0007, 32'h0007_0015);
    run_md("mul_wrap", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_md("divu", MD_DIVU, 100, 7, 14);
    run_md("remu", MD_REMU, 100, 7, 2);
    run_md("divu_big", MD_DIVU, 32'h8000_0000, 3, 32'h2AAA_AAAA);
    run_md("divu_by0", MD_DIVU, 32'h1234, 0, 32'hFFFF_FFFF);
    run_md("remu_by0", MD_REMU, 32'h1234, 0, 32'h1234);
    run_md("remu_by0_top", MD_REMU, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);

    // Operand latching, plus a branch presented while BUSY
    begin
      int n;
      @(posedge clk); #1;
      idle_inputs();
      bus.valid_in = 1; bus.mdOp = MD_MUL; bus.forwardA = 1;
      bus.fwdData = {32'd0, 32'd3}; bus.readData2 = 4;
      @(posedge clk); #1;
      bus.fwdData = {32'd0, 32'd99}; bus.readData1 = 99; bus.readData2 = 99;
      bus.Branch = 1; bus.bne = 0;
      #1;
      chk("busy taken", 32'(bus.taken), 32'd0);
      chk("busy aluRes", bus.aluRes_EX, 32'd0);
      chk("busy res_valid", 32'(bus.res_valid), 32'd0);
      chk("busy stall", 32'(bus.stall), 32'd1);
      n = 1;
      while (bus.stall && n < 100) begin
        n++;
        @(posedge clk); #1;
      end
      chk("latch stall_cycles", 32'(n), 32'd33);
      chk("latch result", bus.aluRes_EX, 32'd12);
      chk("latch res_valid", 32'(bus.res_valid), 32'd1);
      chk("done taken", 32'(bus.taken), 32'd0);
      idle_inputs();
    end

    // Flush at T+10 of a DIVU
    begin
      int rv_seen;
      @(posedge clk); #1;
      idle_inputs();
      bus.valid_in = 1; bus.mdOp = MD_DIVU; bus.readData1 = 100; bus.readData2 = 7;
      repeat (10) @(posedge clk);
      #1;
      bus.flush = 1; bus.valid_in = 0;
      #1;
      chk("flush cycle stall", 32'(bus.stall), 32'd1);
      @(posedge clk); #1;
      bus.flush = 0;
      #1;
      chk("after flush stall", 32'(bus.stall), 32'd0);
      chk("after flush res_valid", 32'(bus.res_valid), 32'd0);
      rv_seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (bus.res_valid || bus.stall) rv_seen++;
      end
      chk("flush no late result", 32'(rv_seen), 32'd0);
    end

    // Reset mid-BUSY, then a fresh MUL
    begin
      @(posedge clk); #1;
      idle_inputs();
      bus.valid_in = 1; bus.mdOp = MD_MUL; bus.readData1 = 5; bus.readData2 = 5;
      repeat (5) @(posedge clk);
      #1;
      reset = 1; bus.valid_in = 0;
      @(posedge clk); #1;
      reset = 0;
      #1;
      chk("reset mid stall", 32'(bus.stall), 32'd0);
      chk("reset mid res_valid", 32'(bus.res_valid), 32'd0);
      run_md("mul_after_reset", MD_MUL, 32'h0001_0003, 32'h0000_0007, 32'h0007_0015);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
Parametrised successor to the single-cycle execute stage. It keeps the forwarding muxes, the ALU and the branch comparator, and generalises the forwarding sources to FWD_SRC pipeline taps. It adds an iterative multiply/divide unit: a small FSM stalls the front of the pipeline while the unit works. The block sits between the ID/EX and EX/MEM registers, and its stall output feeds the hazard unit.

Parameters:
DATA_W, 32, datapath width
FWD_SRC, 2, number of forwarding taps (MEM, WB, ...) in addition to the register-file value
FSEL_W, $clog2(FWD_SRC+1), width of the forwarding selects (derived, not overridable)
SH_W, $clog2(DATA_W), shift-amount width (derived)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
valid_in  input  1  ID/EX holds a valid instruction
flush  input  1  kill the current instruction and abort any multiply/divide
ALUSrc  input  1  ALU operand 2: 0 = forwarded B, 1 = extImm
Branch  input  1  instruction is a conditional branch
bne  input  1  1 = branch-not-equal, 0 = branch-equal
ALUOp  input  4  ALU operation, same encoding as the existing ALU
mdOp  input  2  00 none, 01 MUL (low word), 10 DIVU quotient, 11 REMU remainder
shamt_EX  input  SH_W  shift amount
forwardA, forwardB  input  FSEL_W  0 = register file; k = tap k-1
readData1, readData2, extImm  input  DATA_W  ID/EX operands
fwdData  input  FWD_SRC*DATA_W  forwarding taps; tap k occupies bits [k*DATA_W +: DATA_W]
aluRes_EX  output  DATA_W  result to EX/MEM
forwardB_EX  output  DATA_W  forwarded B, used as store data
taken  output  1  branch resolved as taken
stall  output  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM
res_valid  output  1  aluRes_EX is a valid result this cycle

Behaviour:
- Forwarding
  - Operand A = readData1 if forwardA == 0, else tap forwardA-1. Operand B is selected the same way from readData2 and forwardB.
  - A select value above FWD_SRC yields 0.
- ALU path (mdOp == 00)
  - Purely combinational; aluRes_EX = ALU(A, ALUSrc ? extImm : B).
  - res_valid = valid_in & ~flush; stall = 0.
- Branch comparison
  - taken = valid_in & Branch & ~flush & (state == IDLE) & (bne ? A != op2 : A == op2), where op2 is the ALU operand-2 mux output.
- Multiply/divide FSM, states IDLE, BUSY, DONE
  - IDLE, with valid_in & ~flush & mdOp != 0: latch A, the operand-2 mux output and mdOp; load the counter with DATA_W; stall = 1 combinationally in that same cycle; go to BUSY.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle; the counter decrements; stall = 1; go to DONE when the counter reaches 1 after its step.
  - DONE: aluRes_EX = latched result, res_valid = 1, stall = 0; go unconditionally to IDLE.
- Latency and handshake
  - An operation accepted at cycle T has stall high in cycles T..T+DATA_W; res_valid and the result appear at T+DATA_W+1.
  - Upstream holds the instruction stable while stall = 1.
  - In DONE the same instruction is still presented; the FSM must not re-accept it.
- Latched operands: forwarding changes during BUSY do not affect the result.
- Arithmetic (all unsigned)
  - MUL returns the low DATA_W bits of the product.
  - Divide by zero: quotient = all ones, remainder = dividend, with no exception and the normal latency.
- Outputs while in BUSY: aluRes_EX = 0 and res_valid = 0.
- flush
  - In IDLE: no accept occurs; res_valid = 0.
  - In BUSY or DONE: next state is IDLE; stall still follows the current state in the flush cycle; no res_valid is produced for the aborted operation.
- Reset (synchronous, any state): state = IDLE; counter, latched operands and the partial result/remainder registers are cleared. In the cycle after reset, stall = 0, res_valid = 0, and aluRes_EX/taken show only the combinational values from the inputs.
- Simultaneous reset and flush: reset wins.

Decomposition:
- A shared package, exec_pkg, holds:
  - the mdOp encodings (MD_NONE, MD_MUL, MD_DIVU, MD_REMU);
  - the FSM state typedef;
  - the ALUOp localparams already used by the ALU.
- One sub-module, muldiv_iter, holds:
  - the operand latches, counter and shift/subtract datapath;
  - the interface start, op, a, b, busy, done, result.
- The execute_md top holds the forwarding muxes, the ALU and comparator instances, and the FSM glue.

Test Plan:
- ALU forward: forwardA = 1, tap0 = 0x10, readData2 = 5, ALUOp = add, mdOp = 0 -> aluRes_EX = 0x15 in the same cycle; stall = 0; res_valid = 1.
- MUL: A = 0x0001_0003, B = 0x0000_0007 -> stall high 33 cycles; at T+33 aluRes_EX = 0x0007_0015 and res_valid = 1 for exactly one cycle.
- DIVU/REMU: 100 / 7 -> quotient 14; REMU -> remainder 2. Divisor 0 with dividend 0x1234 -> DIVU gives 0xFFFF_FFFF, REMU gives 0x1234.
- Operand latching: start MUL 3 × 4, then change tap0 and readData1 during BUSY -> result is still 12.
- Branch: bne = 1, A = 5, B = 5 -> taken = 0; with A = 5, B = 6 -> taken = 1. A branch presented while BUSY -> taken = 0.
- Abort: flush at cycle T+10 of a DIVU -> next cycle state IDLE, stall = 0, no res_valid. A reset asserted mid-BUSY gives the same outcome, and a new MUL started right after completes correctly.
